// File: rtl/lsu_issue_queue_v2.sv
// rtl/lsu_issue_queue_v2.sv - in-order load/store issue queue with CDB wakeup and credit-limited DCache issue
module lsu_issue_queue_v2 #(
    parameter int IQ_SIZE      = 8,
    parameter int DISPATCH_W   = 2,
    parameter int CDB_COUNT    = 2,
    parameter int ROB_W        = 6,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [DISPATCH_W-1:0]             disp_valid_i,
    output logic                              disp_ready_o,
    input  logic [DISPATCH_W-1:0]             disp_wmem_i,
    input  logic [DISPATCH_W*2-1:0]           disp_msize_i,
    input  logic [DISPATCH_W-1:0]             disp_msigned_i,
    input  logic [DISPATCH_W*32-1:0]          disp_imm_i,
    input  logic [DISPATCH_W*ROB_W-1:0]       disp_rob_id_i,
    input  logic [DISPATCH_W*2*32-1:0]        disp_src_data_i,
    input  logic [DISPATCH_W*2*ROB_W-1:0]     disp_src_tag_i,
    input  logic [DISPATCH_W*2-1:0]           disp_src_rdy_i,
    input  logic [CDB_COUNT-1:0]              cdb_valid_i,
    input  logic [CDB_COUNT*ROB_W-1:0]        cdb_tag_i,
    input  logic [CDB_COUNT*32-1:0]           cdb_data_i,
    output logic                              req_valid_o,
    input  logic                              req_ready_i,
    output logic [31:0]                       req_vaddr_o,
    output logic [31:0]                       req_wdata_o,
    output logic [3:0]                        req_strb_o,
    output logic [3:0]                        req_rmask_o,
    output logic [1:0]                        req_msize_o,
    output logic                              req_msigned_o,
    output logic                              req_wmem_o,
    output logic [ROB_W-1:0]                  req_rob_id_o,
    output logic                              req_misalign_o,
    input  logic                              resp_valid_i,
    output logic [$clog2(IQ_SIZE):0]          count_o
);
    localparam int PW = $clog2(IQ_SIZE);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(MAX_INFLIGHT + 1);

    logic [PW-1:0]    head, tail;
    logic [FW-1:0]    credit;
    logic [IQ_SIZE-1:0] e_wmem, e_msigned;
    logic [1:0]       e_msize [IQ_SIZE];
    logic [31:0]      e_imm   [IQ_SIZE];
    logic [ROB_W-1:0] e_rob   [IQ_SIZE];
    logic [31:0]      e_data  [IQ_SIZE][2];
    logic [ROB_W-1:0] e_tag   [IQ_SIZE][2];
    logic [1:0]       e_rdy   [IQ_SIZE];

    logic [DISPATCH_W-1:0] acc;
    logic [PW-1:0]    slot      [DISPATCH_W];
    logic [CW-1:0]    acc_cnt, count_next;
    logic [1:0]       lane_rdy  [DISPATCH_W];
    logic [31:0]      lane_data [DISPATCH_W][2];
    logic [1:0]       wake_hit  [IQ_SIZE];
    logic [31:0]      wake_data [IQ_SIZE][2];

    logic [31:0] h_addr, h_op0, h_wdata;
    logic [1:0]  h_size;
    logic [3:0]  h_mask;
    logic        h_mis, h_ready, pop, resp_take;

    // Descending scan so the lowest-index matching CDB port wins.
    function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [32:0] r;
        r = '0;
        for (int c = CDB_COUNT - 1; c >= 0; c--)
            if (cdb_valid_i[c] && cdb_tag_i[c*ROB_W +: ROB_W] == tag)
                r = {1'b1, cdb_data_i[c*32 +: 32]};
        return r;
    endfunction

    always_comb begin
        logic [32:0] hit;
        hit     = '0;
        acc_cnt = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            acc[k]  = disp_ready_o & disp_valid_i[k];
            slot[k] = tail + acc_cnt[PW-1:0];
            acc_cnt = acc_cnt + CW'(acc[k]);
            for (int o = 0; o < 2; o++) begin
                hit = cdb_lookup(disp_src_tag_i[(2*k+o)*ROB_W +: ROB_W]);
                lane_rdy[k][o]  = disp_src_rdy_i[2*k+o] | hit[32];
                lane_data[k][o] = (!disp_src_rdy_i[2*k+o] && hit[32]) ? hit[31:0]
                                                                      : disp_src_data_i[(2*k+o)*32 +: 32];
            end
        end
    end

    always_comb begin
        logic [32:0] hit;
        hit = '0;
        for (int i = 0; i < IQ_SIZE; i++)
            for (int o = 0; o < 2; o++) begin
                hit = cdb_lookup(e_tag[i][o]);
                wake_hit[i][o]  = !e_rdy[i][o] & hit[32];
                wake_data[i][o] = hit[31:0];
            end
    end

    always_comb begin
        h_op0  = e_data[head][0];
        h_size = e_msize[head];
        h_addr = e_data[head][1] + e_imm[head];
        case (h_size)
            2'd0:    begin h_mask = 4'b0001 << h_addr[1:0]; h_wdata = h_op0 << {h_addr[1:0], 3'b000}; end
            2'd1:    begin h_mask = 4'b0011 << h_addr[1:0]; h_wdata = h_op0 << {h_addr[1], 4'b0000}; end
            default: begin h_mask = 4'b1111;                h_wdata = h_op0; end
        endcase
        h_mis   = (h_size == 2'd1 && h_addr[0]) || (h_size[1] && h_addr[1:0] != 2'b00);
        // Loads only depend on the base address operand.
        h_ready = e_rdy[head][1] & (e_rdy[head][0] | ~e_wmem[head]);
        pop     = (count_o != '0) && h_ready && (!req_valid_o || req_ready_i)
                  && (credit < FW'(MAX_INFLIGHT));
    end

    assign resp_take  = resp_valid_i && (credit != '0);
    assign count_next = count_o + acc_cnt - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0; tail <= '0; count_o <= '0; credit <= '0; disp_ready_o <= 1'b1;
        end else if (flush) begin
            head <= '0; tail <= '0; count_o <= '0; credit <= '0; disp_ready_o <= 1'b1;
        end else begin
            head         <= head + PW'(pop);
            tail         <= tail + acc_cnt[PW-1:0];
            count_o      <= count_next;
            credit       <= credit + FW'(pop) - FW'(resp_take);
            disp_ready_o <= (IQ_SIZE - int'(count_next)) >= DISPATCH_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                e_wmem[i] <= 1'b0; e_msigned[i] <= 1'b0; e_msize[i] <= '0;
                e_imm[i] <= '0; e_rob[i] <= '0; e_rdy[i] <= '0;
                for (int o = 0; o < 2; o++) begin
                    e_data[i][o] <= '0; e_tag[i][o] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < IQ_SIZE; i++)
                for (int o = 0; o < 2; o++)
                    if (wake_hit[i][o]) begin
                        e_rdy[i][o]  <= 1'b1;
                        e_data[i][o] <= wake_data[i][o];
                    end
            // Dispatch writes come last so a freshly allocated slot overrides stale wakeups.
            for (int k = 0; k < DISPATCH_W; k++)
                if (acc[k]) begin
                    e_wmem[slot[k]]    <= disp_wmem_i[k];
                    e_msigned[slot[k]] <= disp_msigned_i[k];
                    e_msize[slot[k]]   <= disp_msize_i[2*k +: 2];
                    e_imm[slot[k]]     <= disp_imm_i[k*32 +: 32];
                    e_rob[slot[k]]     <= disp_rob_id_i[k*ROB_W +: ROB_W];
                    for (int o = 0; o < 2; o++) begin
                        e_data[slot[k]][o] <= lane_data[k][o];
                        e_tag[slot[k]][o]  <= disp_src_tag_i[(2*k+o)*ROB_W +: ROB_W];
                        e_rdy[slot[k]][o]  <= lane_rdy[k][o];
                    end
                end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            req_valid_o <= 1'b0; req_vaddr_o <= '0; req_wdata_o <= '0; req_strb_o <= '0;
            req_rmask_o <= '0; req_msize_o <= '0; req_msigned_o <= 1'b0; req_wmem_o <= 1'b0;
            req_rob_id_o <= '0; req_misalign_o <= 1'b0;
        end else if (pop) begin
            req_valid_o    <= 1'b1;
            req_vaddr_o    <= h_addr;
            req_wdata_o    <= h_wdata;
            req_strb_o     <= (e_wmem[head] && !h_mis) ? h_mask : 4'b0000;
            req_rmask_o    <= (!e_wmem[head] && !h_mis) ? h_mask : 4'b0000;
            req_msize_o    <= h_size;
            req_msigned_o  <= e_msigned[head];
            req_wmem_o     <= e_wmem[head];
            req_rob_id_o   <= e_rob[head];
            req_misalign_o <= h_mis;
        end else if (req_valid_o && req_ready_i) begin
            req_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_issue_queue_v2.sv
// tb/tb_lsu_issue_queue_v2.sv - scoreboard bench for lsu_issue_queue_v2
module tb_lsu_issue_queue_v2;
    localparam int IQ = 8, DW = 2, CDB = 2, RW = 6, MI = 4;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [DW-1:0] disp_valid_i, disp_wmem_i, disp_msigned_i;
    logic disp_ready_o;
    logic [DW*2-1:0] disp_msize_i, disp_src_rdy_i;
    logic [DW*32-1:0] disp_imm_i;
    logic [DW*RW-1:0] disp_rob_id_i;
    logic [DW*64-1:0] disp_src_data_i;
    logic [DW*2*RW-1:0] disp_src_tag_i;
    logic [CDB-1:0] cdb_valid_i;
    logic [CDB*RW-1:0] cdb_tag_i;
    logic [CDB*32-1:0] cdb_data_i;
    logic req_valid_o, req_ready_i, req_msigned_o, req_wmem_o, req_misalign_o, resp_valid_i;
    logic [31:0] req_vaddr_o, req_wdata_o;
    logic [3:0] req_strb_o, req_rmask_o;
    logic [1:0] req_msize_o;
    logic [RW-1:0] req_rob_id_o;
    logic [$clog2(IQ):0] count_o;

    lsu_issue_queue_v2 #(.IQ_SIZE(IQ), .DISPATCH_W(DW), .CDB_COUNT(CDB), .ROB_W(RW), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_wmem_i(disp_wmem_i),
        .disp_msize_i(disp_msize_i), .disp_msigned_i(disp_msigned_i), .disp_imm_i(disp_imm_i),
        .disp_rob_id_i(disp_rob_id_i), .disp_src_data_i(disp_src_data_i), .disp_src_tag_i(disp_src_tag_i),
        .disp_src_rdy_i(disp_src_rdy_i), .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
        .cdb_data_i(cdb_data_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_vaddr_o(req_vaddr_o), .req_wdata_o(req_wdata_o), .req_strb_o(req_strb_o),
        .req_rmask_o(req_rmask_o), .req_msize_o(req_msize_o), .req_msigned_o(req_msigned_o),
        .req_wmem_o(req_wmem_o), .req_rob_id_o(req_rob_id_o), .req_misalign_o(req_misalign_o),
        .resp_valid_i(resp_valid_i), .count_o(count_o));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [31:0]   vaddr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [3:0]    rmask;
        logic [1:0]    msize;
        logic          msigned;
        logic          wmem;
        logic          mis;
    } req_t;

    req_t exp_q[$];
    int total = 0, bad = 0, handshakes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic exp_push(input logic [RW-1:0] rob, input logic [31:0] va, input logic [31:0] wd,
                            input logic [3:0] st, input logic [3:0] rm, input logic [1:0] ms,
                            input logic sg, input logic wm, input logic mi);
        req_t r;
        r = {rob, va, wd, st, rm, ms, sg, wm, mi};
        exp_q.push_back(r);
    endtask

    task automatic set_lane(input int k, input logic wm, input logic [1:0] ms, input logic sg,
                            input logic [31:0] imm, input logic [RW-1:0] rob,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [RW-1:0] t0, input logic [RW-1:0] t1,
                            input logic r0, input logic r1);
        disp_valid_i[k]                  = 1'b1;
        disp_wmem_i[k]                   = wm;
        disp_msize_i[2*k +: 2]           = ms;
        disp_msigned_i[k]                = sg;
        disp_imm_i[k*32 +: 32]           = imm;
        disp_rob_id_i[k*RW +: RW]        = rob;
        disp_src_data_i[(2*k)*32 +: 32]  = d0;
        disp_src_data_i[(2*k+1)*32 +: 32] = d1;
        disp_src_tag_i[(2*k)*RW +: RW]   = t0;
        disp_src_tag_i[(2*k+1)*RW +: RW] = t1;
        disp_src_rdy_i[2*k]              = r0;
        disp_src_rdy_i[2*k+1]            = r1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        disp_valid_i = '0;
        cdb_valid_i  = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && req_valid_o && req_ready_i) begin
            req_t got, want;
            got = {req_rob_id_o, req_vaddr_o, req_wdata_o, req_strb_o, req_rmask_o,
                   req_msize_o, req_msigned_o, req_wmem_o, req_misalign_o};
            handshakes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: got %h expected none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL req_fields rob=%0d: got %h expected %h", want.rob, got, want);
                end
            end
        end
    end

    initial begin
        disp_valid_i = '0; disp_wmem_i = '0; disp_msigned_i = '0; disp_msize_i = '0;
        disp_src_rdy_i = '0; disp_imm_i = '0; disp_rob_id_i = '0; disp_src_data_i = '0;
        disp_src_tag_i = '0; cdb_valid_i = '0; cdb_tag_i = '0; cdb_data_i = '0;
        req_ready_i = 1'b1; resp_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_disp_ready", disp_ready_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_req_valid", req_valid_o, 0);
        chk("rst_vaddr", req_vaddr_o, 0);

        // Two ready ops on both lanes, issued in order.
        set_lane(0, 0, 2, 0, 32'h4, 6'd5, 32'h0, 32'h100, 0, 0, 1, 1);
        exp_push(6'd5, 32'h104, 32'h0, 4'h0, 4'hF, 2, 0, 0, 0);
        set_lane(1, 1, 2, 0, 32'h0, 6'd6, 32'h12345678, 32'h200, 0, 0, 1, 1);
        exp_push(6'd6, 32'h200, 32'h12345678, 4'hF, 4'h0, 2, 0, 1, 0);
        step();
        chk("t1_count", count_o, 2);
        chk("t1_valid_early", req_valid_o, 0);
        step();
        chk("t1_valid_first", req_valid_o, 1);
        chk("t1_rob_first", req_rob_id_o, 5);
        step();
        chk("t1_rob_second", req_rob_id_o, 6);
        step();
        chk("t1_idle_valid", req_valid_o, 0);
        chk("t1_idle_count", count_o, 0);
        do_flush();

        // Only lane 1 valid: compacts into the tail slot.
        set_lane(1, 0, 0, 0, 32'h1, 6'd7, 32'h0, 32'h300, 0, 0, 1, 1);
        exp_push(6'd7, 32'h301, 32'h0, 4'h0, 4'b0010, 0, 0, 0, 0);
        step();
        chk("t2_count", count_o, 1);
        step();
        chk("t2_rob", req_rob_id_o, 7);
        step();

        // Half load with store-data operand pending still issues.
        set_lane(0, 0, 1, 0, 32'h2, 6'd8, 32'h0, 32'h1000, 6'd20, 0, 0, 1);
        exp_push(6'd8, 32'h1002, 32'h0, 4'h0, 4'b1100, 1, 0, 0, 0);
        step();
        step();
        chk("t3_valid", req_valid_o, 1);
        step();

        // Byte store waits for its base address; two CDB ports hit, lowest wins.
        set_lane(0, 1, 0, 0, 32'h1, 6'd9, 32'hAB, 32'h0, 0, 6'd9, 1, 0);
        exp_push(6'd9, 32'h2001, 32'h0000AB00, 4'b0010, 4'h0, 0, 0, 1, 0);
        step();
        chk("t4_wait_valid", req_valid_o, 0);
        cdb_valid_i = 2'b11;
        cdb_tag_i   = {6'd9, 6'd9};
        cdb_data_i  = {32'h3000, 32'h2000};
        step();
        chk("t4_capture_valid", req_valid_o, 0);
        step();
        chk("t4_issue_valid", req_valid_o, 1);
        step();

        // Misaligned signed word load.
        set_lane(0, 0, 2, 1, 32'h6, 6'd10, 32'h55, 32'h1000, 0, 0, 1, 1);
        exp_push(6'd10, 32'h1006, 32'h55, 4'h0, 4'h0, 2, 1, 0, 1);
        step();
        step();
        chk("t5_misalign", req_misalign_o, 1);
        step();
        do_flush();

        // Credit limit: five ready ops, no responses.
        resp_valid_i = 1'b0;
        handshakes = 0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 2; k++)
                if (2*p + k < 5) begin
                    set_lane(k, 0, 2, 0, 32'h0, 6'(11 + 2*p + k), 32'h0, 32'h400, 0, 0, 1, 1);
                    exp_push(6'(11 + 2*p + k), 32'h400, 32'h0, 4'h0, 4'hF, 2, 0, 0, 0);
                end
            step();
        end
        repeat (4) step();
        chk("t6_blocked_valid", req_valid_o, 0);
        chk("t6_issued", handshakes, 4);
        chk("t6_count", count_o, 1);
        resp_valid_i = 1'b1;
        step();
        resp_valid_i = 1'b0;
        chk("t6_resp_cycle_valid", req_valid_o, 0);
        step();
        chk("t6_fifth_valid", req_valid_o, 1);
        chk("t6_fifth_rob", req_rob_id_o, 15);
        step();
        do_flush();

        // Fill with stalled DCache and pending operands, then flush mid-stream.
        req_ready_i = 1'b0;
        set_lane(0, 0, 2, 0, 32'h0, 6'd20, 32'h0, 32'h500, 0, 0, 1, 1);
        set_lane(1, 0, 2, 0, 32'h0, 6'd21, 32'h0, 32'h0, 0, 6'd30, 1, 0);
        step();
        chk("t7_count_2", count_o, 2);
        for (int p = 0; p < 3; p++) begin
            set_lane(0, 0, 2, 0, 32'h0, 6'(22 + 2*p), 32'h0, 32'h0, 0, 6'd30, 1, 0);
            set_lane(1, 0, 2, 0, 32'h0, 6'(23 + 2*p), 32'h0, 32'h0, 0, 6'd30, 1, 0);
            step();
            if (p == 0) begin
                chk("t7_held_valid", req_valid_o, 1);
                chk("t7_held_rob", req_rob_id_o, 20);
                chk("t7_count_3", count_o, 3);
            end
            if (p == 1) chk("t7_count_5", count_o, 5);
        end
        chk("t7_count_7", count_o, 7);
        chk("t7_ready_low", disp_ready_o, 0);
        chk("t7_hold_rob", req_rob_id_o, 20);
        set_lane(0, 0, 2, 0, 32'h0, 6'd40, 32'h0, 32'h0, 0, 0, 1, 1);
        set_lane(1, 0, 2, 0, 32'h0, 6'd41, 32'h0, 32'h0, 0, 0, 1, 1);
        step();
        chk("t7_reject_count", count_o, 7);
        do_flush();
        chk("fl_count", count_o, 0);
        chk("fl_valid", req_valid_o, 0);
        chk("fl_ready", disp_ready_o, 1);
        chk("fl_vaddr", req_vaddr_o, 0);
        req_ready_i = 1'b1;
        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
